// File: rtl/mem_arbiter.sv
// Byte-wide memory port arbiter between the CPU and a DMA/loader requester.
// Registered grant, burst quota with CPU lock, registered per-requester read-valid.
module mem_arbiter #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          cpu_lock,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StCpu, StDma} state_t;

    localparam logic [3:0] CntMax = 4'(BURST - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       last_dma;
    logic       cpu_acc;
    logic       dma_acc;

    // No access is issued while reset is held, even if a grant is still standing.
    assign cpu_acc = cpu_gnt & cpu_req & reset;
    assign dma_acc = dma_gnt & dma_req & reset;

    assign mem_re    = (cpu_acc & ~cpu_we) | (dma_acc & ~dma_we);
    assign mem_we    = (cpu_acc & cpu_we) | (dma_acc & dma_we);
    assign mem_addr  = cpu_gnt ? cpu_addr : (dma_gnt ? dma_addr : '0);
    assign mem_wdata = cpu_gnt ? cpu_wdata : (dma_gnt ? dma_wdata : '0);

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= StIdle;
            cnt        <= 4'd0;
            last_dma   <= 1'b1;
            cpu_gnt    <= 1'b0;
            dma_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_acc & ~cpu_we;
            dma_rvalid <= dma_acc & ~dma_we;
            unique case (state)
                StIdle: begin
                    // On a tie the side not served last wins.
                    if (cpu_req && (!dma_req || last_dma)) begin
                        state    <= StCpu;
                        cpu_gnt  <= 1'b1;
                        cnt      <= 4'd0;
                        last_dma <= 1'b0;
                    end else if (dma_req) begin
                        state    <= StDma;
                        dma_gnt  <= 1'b1;
                        cnt      <= 4'd0;
                        last_dma <= 1'b1;
                    end
                end
                StCpu: begin
                    if (!cpu_req) begin
                        state   <= StIdle;
                        cpu_gnt <= 1'b0;
                        cnt     <= 4'd0;
                    end else if (cnt == CntMax && dma_req && !cpu_lock) begin
                        state    <= StDma;
                        cpu_gnt  <= 1'b0;
                        dma_gnt  <= 1'b1;
                        cnt      <= 4'd0;
                        last_dma <= 1'b1;
                    end else if (cnt != CntMax) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                StDma: begin
                    if (!dma_req) begin
                        state   <= StIdle;
                        dma_gnt <= 1'b0;
                        cnt     <= 4'd0;
                    end else if (cnt == CntMax && cpu_req) begin
                        state    <= StCpu;
                        dma_gnt  <= 1'b0;
                        cpu_gnt  <= 1'b1;
                        cnt      <= 4'd0;
                        last_dma <= 1'b0;
                    end else if (cnt != CntMax) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state   <= StIdle;
                    cpu_gnt <= 1'b0;
                    dma_gnt <= 1'b0;
                    cnt     <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Per-cycle vector table for mem_arbiter with a read-data scoreboard,
// followed by a hand-written release/request hand-over sequence.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_lock;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_gnt, cpu_stall, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       dma_req, dma_we;
    logic [7:0] dma_addr, dma_wdata;
    logic       dma_gnt, dma_rvalid;
    logic [7:0] dma_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_re, mem_we;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.AW(8), .DW(8), .BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        case (a)
            8'h10:   return 8'hA5;
            8'h30:   return 8'h5A;
            8'h40:   return 8'h11;
            8'h50:   return 8'h22;
            default: return a ^ 8'h55;
        endcase
    endfunction

    // Memory: synchronous read, data valid the cycle after mem_re.
    logic [7:0] mem [256];
    bit         written [256];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        if (mem_re) mem_rdata <= written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    end

    typedef struct {
        bit         rst, creq, cwe, lk;
        logic [7:0] ca, cwd;
        bit         dreq, dwe;
        logic [7:0] da, dwd;
        bit         ecg, edg, ere, ewe;
        logic [7:0] ea, ewd;
        bit         ecrv, edrv;
    } vec_t;

    typedef struct {
        bit         cpu;
        logic [7:0] data;
    } sb_t;

    vec_t       vecs[$];
    sb_t        sbq[$];
    logic [7:0] model_mem [256];

    function automatic void add(
        input bit rst, input bit creq, input bit cwe, input bit lk,
        input logic [7:0] ca, input logic [7:0] cwd,
        input bit dreq, input bit dwe, input logic [7:0] da, input logic [7:0] dwd,
        input bit ecg, input bit edg, input bit ere, input bit ewe,
        input logic [7:0] ea, input logic [7:0] ewd, input bit ecrv, input bit edrv);
        vec_t v;
        v = '{rst, creq, cwe, lk, ca, cwd, dreq, dwe, da, dwd,
              ecg, edg, ere, ewe, ea, ewd, ecrv, edrv};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst;
        cpu_req = v.creq; cpu_we = v.cwe; cpu_lock = v.lk; cpu_addr = v.ca; cpu_wdata = v.cwd;
        dma_req = v.dreq; dma_we = v.dwe; dma_addr = v.da; dma_wdata = v.dwd;
    endtask

    initial begin
        vec_t v;
        sb_t  s;
        bit   own_cpu;
        for (int i = 0; i < 256; i++) model_mem[i] = init_val(8'(i));
        v = '{0, 0, 0, 0, 8'h0, 8'h0, 0, 0, 8'h0, 8'h0, 0, 0, 0, 0, 8'h0, 8'h0, 0, 0};
        drive(v);
        repeat (2) @(posedge clk);

        // Reset held with both requests pending: nothing is granted.
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 0, 8'h10, 0, 1, 0, 8'h30, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        // Both reads held: CPU wins first tie, then 4/4 alternation.
        add(1, 1, 0, 0, 8'h10, 0, 1, 0, 8'h30, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            own_cpu = (i <= 4) || (i >= 9);
            add(1, 1, 0, 0, 8'h10, 0, 1, 0, 8'h30, 0, own_cpu, !own_cpu, 1, 0,
                own_cpu ? 8'h10 : 8'h30, 0, (i >= 2 && i <= 5) || i >= 10, i >= 6 && i <= 9);
        end
        add(1, 0, 0, 0, 8'h10, 0, 0, 0, 8'h30, 0, 0, 1, 0, 0, 8'h30, 0, 1, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        // Single CPU read of 0xA5 at 0x10.
        add(1, 1, 0, 0, 8'h10, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        add(1, 1, 0, 0, 8'h10, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 8'h10, 0, 0, 0);
        add(1, 0, 0, 0, 8'h10, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h10, 0, 1, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        // Locked CPU burst of 8, then one unlocked access at the cap hands over.
        add(1, 1, 0, 1, 8'h40, 0, 0, 0, 8'h50, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 8; i++)
            add(1, 1, 0, 1, 8'h40, 0, 1, 0, 8'h50, 0, 1, 0, 1, 0, 8'h40, 0, i >= 2, 0);
        add(1, 1, 0, 0, 8'h40, 0, 1, 0, 8'h50, 0, 1, 0, 1, 0, 8'h40, 0, 1, 0);
        add(1, 0, 0, 0, 8'h40, 0, 1, 0, 8'h50, 0, 0, 1, 1, 0, 8'h50, 0, 1, 0);
        add(1, 0, 0, 0, 8'h40, 0, 1, 0, 8'h50, 0, 0, 1, 1, 0, 8'h50, 0, 0, 1);
        add(1, 0, 0, 0, 8'h40, 0, 0, 0, 8'h50, 0, 0, 1, 0, 0, 8'h50, 0, 0, 1);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        // DMA write 0x3C to 0x20, then CPU reads it back.
        add(1, 0, 0, 0, 8'h00, 0, 1, 1, 8'h20, 8'h3C, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        add(1, 0, 0, 0, 8'h00, 0, 1, 1, 8'h20, 8'h3C, 0, 1, 0, 1, 8'h20, 8'h3C, 0, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h20, 8'h3C, 0, 1, 0, 0, 8'h20, 8'h3C, 0, 0);
        add(1, 1, 0, 0, 8'h20, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        add(1, 1, 0, 0, 8'h20, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 8'h20, 0, 0, 0);
        add(1, 0, 0, 0, 8'h20, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h20, 0, 1, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        // Reset in the cycle after a read: access blocked, rvalid gone next cycle.
        add(1, 1, 0, 0, 8'h10, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        add(1, 1, 0, 0, 8'h10, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 8'h10, 0, 0, 0);
        add(0, 1, 0, 0, 8'h10, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h10, 0, 1, 0);
        add(1, 0, 0, 0, 8'h10, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            @(posedge clk); #1;
            drive(v);
            @(negedge clk);
            if (cpu_rvalid || dma_rvalid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL v%0d.sb_empty: got rvalid expected none pending", k);
                end else begin
                    s = sbq.pop_front();
                    chk($sformatf("v%0d.rv_owner", k), 32'(cpu_rvalid), 32'(s.cpu));
                    chk($sformatf("v%0d.rdata", k), cpu_rvalid ? cpu_rdata : dma_rdata, s.data);
                end
            end
            chk($sformatf("v%0d.cpu_gnt", k), 32'(cpu_gnt), 32'(v.ecg));
            chk($sformatf("v%0d.dma_gnt", k), 32'(dma_gnt), 32'(v.edg));
            chk($sformatf("v%0d.mem_re", k), 32'(mem_re), 32'(v.ere));
            chk($sformatf("v%0d.mem_we", k), 32'(mem_we), 32'(v.ewe));
            chk($sformatf("v%0d.mem_addr", k), mem_addr, v.ea);
            chk($sformatf("v%0d.mem_wdata", k), mem_wdata, v.ewd);
            chk($sformatf("v%0d.cpu_rvalid", k), 32'(cpu_rvalid), 32'(v.ecrv));
            chk($sformatf("v%0d.dma_rvalid", k), 32'(dma_rvalid), 32'(v.edrv));
            if (v.ere) begin
                s.cpu  = v.ecg;
                s.data = model_mem[v.ea];
                sbq.push_back(s);
            end
            if (v.ewe) model_mem[v.ea] = v.ewd;
            if (!v.rst) sbq.delete();
        end
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        // CPU releases while DMA requests in the same cycle: one idle gap.
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10; dma_req = 0;
        @(negedge clk);
        chk("ho.stall_c0", 32'(cpu_stall), 32'd1);
        chk("ho.gnt_c0", 32'(cpu_gnt), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ho.gnt_c1", 32'(cpu_gnt), 32'd1);
        chk("ho.stall_c1", 32'(cpu_stall), 32'd0);
        chk("ho.re_c1", 32'(mem_re), 32'd1);
        @(posedge clk); #1;
        cpu_req = 0; dma_req = 1; dma_we = 0; dma_addr = 8'h30;
        @(negedge clk);
        chk("ho.cpu_gnt_c2", 32'(cpu_gnt), 32'd1);
        chk("ho.dma_gnt_c2", 32'(dma_gnt), 32'd0);
        chk("ho.crv_c2", 32'(cpu_rvalid), 32'd1);
        chk("ho.rdata_c2", cpu_rdata, 8'hA5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ho.cpu_gnt_c3", 32'(cpu_gnt), 32'd0);
        chk("ho.dma_gnt_c3", 32'(dma_gnt), 32'd0);
        chk("ho.re_c3", 32'(mem_re), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ho.dma_gnt_c4", 32'(dma_gnt), 32'd1);
        chk("ho.addr_c4", mem_addr, 8'h30);
        @(posedge clk); #1;
        dma_req = 0;
        @(negedge clk);
        chk("ho.drv_c5", 32'(dma_rvalid), 32'd1);
        chk("ho.drdata_c5", dma_rdata, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single byte-wide memory port between the multicycle CPU controller/datapath and a DMA/loader requester. The block issues a registered grant, muxes the owner's address, data and strobes onto the memory, and returns read-valid one cycle after each read. Locked CPU bursts are never split, and a burst-length quota prevents either side from starving the other. It sits between the CPU memory interface and the memory.

## Interface
- AW, 8, address width
- DW, 8, data width
- BURST, 4, max accesses per grant while the other side waits (range 1..15)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  1 = write, 0 = read
- cpu_lock  in  1  holds the grant across accesses (asserted during FETCH1..FETCH3)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU owns the port this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  DW  read data (= mem_rdata)
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  same meanings for DMA
- dma_gnt, dma_rvalid, dma_rdata  out  1/1/DW  same meanings for DMA
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_rdata  in  DW  memory read data, valid one cycle after mem_re

## Operation
- States: IDLE, CPU, DMA. cpu_gnt = (state==CPU); dma_gnt = (state==DMA).
- Access happens in any cycle where the owner is granted and its req is high:
  - mem_re = req & ~we; mem_we = req & we.
  - mem_addr/mem_wdata come from the owner; they are 0 in IDLE.
- IDLE:
  - Only cpu_req -> CPU. Only dma_req -> DMA. Neither -> IDLE.
  - Both -> the side not served last (last-owner flag). Reset sets last = DMA, so the CPU wins the first tie.
- CPU/DMA, evaluated at each edge:
  - Owner req low -> IDLE.
  - Owner req high, cnt == BURST-1, other req high, and (owner is DMA or cpu_lock low) -> switch directly to the other owner, cnt = 0.
  - Otherwise stay; cnt increments on each access and saturates at BURST-1.
- cpu_lock high forbids preemption of the CPU for any count. The DMA has no lock.
- The last-owner flag updates on every grant entry.
- cnt (4 bits) clears on entry to any state.
- rvalid: registered. x_rvalid = 1 the cycle after a read access by x. x_rdata = mem_rdata (combinational).

## Timing
- Reset (reset==0 at an edge): state = IDLE, cnt = 0, last = DMA, rvalid flags = 0.
  - All outputs are 0 the following cycle.
  - An in-flight rvalid is discarded; no access is issued.
- Request-to-grant latency is 1 cycle from IDLE (req sampled at edge t, gnt high in cycle t+1). Read data arrives at t+2.
- A held request gets one access per cycle with no bubbles.
- A switch has zero bubble cycles: the old owner's last access is cycle n, the new owner's first access is cycle n+1.
- A requester dropping req in cycle n gets no access in n. gnt falls at n+1.
- A requester must hold addr/we/wdata stable while req is high and gnt is low.
- Simultaneous release by the owner and request by the other: passes through IDLE (1-cycle gap).

## Test plan
- Reset: hold reset=0 with both reqs high for 3 cycles -> all outputs 0. Release -> cpu_gnt=1 the next cycle (tie, last=DMA).
- CPU read: cpu_req, addr 0x10, mem holds 0xA5 -> cpu_gnt at t+1, mem_re=1 with mem_addr=0x10, cpu_rvalid=1 and cpu_rdata=0xA5 at t+2.
- Fairness, BURST=4, both requests held, lock low:
  - CPU accesses 4 cycles, then DMA 4 cycles, alternating.
  - dma_stall equivalent never exceeds 4 cycles.
- Lock: cpu_lock high for 8 accesses with dma_req held -> CPU keeps the grant all 8 cycles. DMA is granted the cycle after the first unlocked access at cnt==3.
- DMA write 0x3C to 0x20 while the CPU is idle -> mem_we=1, mem_addr=0x20, mem_wdata=0x3C for one cycle. dma_rvalid stays 0.
- Reset mid-read: assert reset in the cycle after the access -> cpu_rvalid=0 next cycle, state IDLE.
